branch_redirect_ctrl: RTL and testbench

Execute-stage branch resolution and PC-redirect controller for the RV32I core. It sits directly downstream of the branch comparator and consumes its masked result together with the instruction's PC, immediate and rs1. It computes the control-transfer target and checks its alignment. On a taken transfer it drives a held redirect handshake to fetch, then flushes and stalls the younger pipeline stages for a programmable number of cycles.

---
 rtl/control_pkg.sv | 26 ++
 rtl/instructions_pkg.sv | 10 +
 rtl/branch_redirect_ctrl_target_calc.sv | 31 +++
 rtl/branch_redirect_ctrl.sv | 154 +++++++++++++++
 tb/tb_branch_redirect_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/control_pkg.sv
`default_nettype none
// ============================================================================
// Module   : control_pkg
// Brief    : Control-path types: comparator result, branch kinds, redirect FSM.
// Revision : 1.0 - initial release
// ============================================================================
package control_pkg;
    typedef enum logic {
        BRES_NOT_TAKEN = 1'b0,
        BRES_TAKEN     = 1'b1
    } e_branch_result;

    typedef enum logic [1:0] {
        BR_NONE = 2'd0,
        BR_COND = 2'd1,
        BR_JAL  = 2'd2,
        BR_JALR = 2'd3
    } e_br_kind;

    typedef enum logic [1:0] {
        RD_IDLE     = 2'd0,
        RD_REDIRECT = 2'd1,
        RD_FLUSH    = 2'd2
    } e_redirect_state;
endpackage
`default_nettype wire

// File: rtl/instructions_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instructions_pkg
// Brief    : ISA-wide constants shared across the RV32I core.
// Revision : 1.0 - initial release
// ============================================================================
package instructions_pkg;
    localparam int unsigned XLEN = 32;
endpackage
`default_nettype wire

// File: rtl/branch_redirect_ctrl_target_calc.sv
`default_nettype none
// ============================================================================
// Module   : branch_target_calc
// Brief    : Combinational control-transfer target and alignment check.
// Revision : 1.0 - initial release
// ============================================================================
module branch_target_calc
    import control_pkg::*;
#(
    parameter int unsigned DATA_W = instructions_pkg::XLEN
) (
    input  logic [DATA_W-1:0] pc,
    input  logic [DATA_W-1:0] imm,
    input  logic [DATA_W-1:0] rs1_data,
    input  e_br_kind          br_kind,
    output logic [DATA_W-1:0] target,
    output logic              misaligned
);
    logic [DATA_W-1:0] w_sum;

    always_comb begin
        w_sum = ((br_kind == BR_JALR) ? rs1_data : pc) + imm;
        target = w_sum;
        if (br_kind == BR_JALR) begin
            target[0] = 1'b0;
        end
        // No compressed instructions, so any target not on a 4-byte boundary faults.
        misaligned = target[1];
    end
endmodule
`default_nettype wire

// File: rtl/branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : branch_redirect_ctrl
// Brief    : Execute-stage branch resolution, fetch redirect and flush/stall
//            sequencing. Optional perf counters under BRANCH_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module branch_redirect_ctrl
    import control_pkg::*;
#(
    parameter int unsigned DATA_W       = instructions_pkg::XLEN,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                ex_valid,
    input  e_br_kind            br_kind,
    input  e_branch_result      cmp_result,
    input  logic [DATA_W-1:0]   pc,
    input  logic [DATA_W-1:0]   imm,
    input  logic [DATA_W-1:0]   rs1_data,
    output logic                redirect_valid,
    input  logic                redirect_ready,
    output logic [DATA_W-1:0]   redirect_pc,
    output logic                flush,
    output logic                stall,
    output logic                misalign_exc,
    output logic [DATA_W-1:0]   misalign_tval
`ifdef BRANCH_PERF_CNT_EN
    ,
    output logic [31:0]         perf_cond_cnt,
    output logic [31:0]         perf_taken_cnt
`endif
);
    localparam logic [3:0] C_CNT_LOAD = 4'((FLUSH_CYCLES > 0) ? FLUSH_CYCLES - 1 : 0);

    e_redirect_state   state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [DATA_W-1:0] redirect_pc_q, redirect_pc_d;
    logic              misalign_exc_q, misalign_exc_d;
    logic [DATA_W-1:0] misalign_tval_q, misalign_tval_d;

    logic [DATA_W-1:0] w_target;
    logic              w_misaligned;
    logic              w_accept;
    logic              w_taken;
    logic              w_fault;
    logic              w_go;

    branch_target_calc #(.DATA_W(DATA_W)) u_target_calc (
        .pc         (pc),
        .imm        (imm),
        .rs1_data   (rs1_data),
        .br_kind    (br_kind),
        .target     (w_target),
        .misaligned (w_misaligned)
    );

    always_comb begin
        w_accept = ex_valid && (state_q == RD_IDLE);
        w_taken  = (br_kind == BR_JAL) || (br_kind == BR_JALR) ||
                   ((br_kind == BR_COND) && (cmp_result == BRES_TAKEN));
        w_fault  = w_accept && w_taken && w_misaligned;
        w_go     = w_accept && w_taken && !w_misaligned;

        state_d         = state_q;
        cnt_d           = cnt_q;
        redirect_pc_d   = redirect_pc_q;
        misalign_exc_d  = w_fault;
        misalign_tval_d = w_fault ? w_target : misalign_tval_q;

        case (state_q)
            RD_IDLE: begin
                if (w_go) begin
                    state_d       = RD_REDIRECT;
                    redirect_pc_d = w_target;
                end
            end
            RD_REDIRECT: begin
                if (redirect_ready) begin
                    if (FLUSH_CYCLES == 0) begin
                        state_d = RD_IDLE;
                    end else begin
                        state_d = RD_FLUSH;
                        cnt_d   = C_CNT_LOAD;
                    end
                end
            end
            RD_FLUSH: begin
                if (cnt_q == 4'd0) begin
                    state_d = RD_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = RD_IDLE;
        endcase

        redirect_valid = (state_q == RD_REDIRECT);
        flush          = (state_q != RD_IDLE);
        stall          = (state_q != RD_IDLE);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q         <= RD_IDLE;
            cnt_q           <= 4'd0;
            redirect_pc_q   <= '0;
            misalign_exc_q  <= 1'b0;
            misalign_tval_q <= '0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            redirect_pc_q   <= redirect_pc_d;
            misalign_exc_q  <= misalign_exc_d;
            misalign_tval_q <= misalign_tval_d;
        end
    end

    assign redirect_pc   = redirect_pc_q;
    assign misalign_exc  = misalign_exc_q;
    assign misalign_tval = misalign_tval_q;

`ifdef BRANCH_PERF_CNT_EN
    logic [31:0] perf_cond_cnt_q, perf_cond_cnt_d;
    logic [31:0] perf_taken_cnt_q, perf_taken_cnt_d;

    // Misaligned taken transfers still count as taken.
    always_comb begin
        perf_cond_cnt_d  = perf_cond_cnt_q;
        perf_taken_cnt_d = perf_taken_cnt_q;
        if (w_accept && (br_kind == BR_COND)) begin
            perf_cond_cnt_d = perf_cond_cnt_q + 32'd1;
        end
        if (w_accept && w_taken) begin
            perf_taken_cnt_d = perf_taken_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_cond_cnt_q  <= 32'd0;
            perf_taken_cnt_q <= 32'd0;
        end else begin
            perf_cond_cnt_q  <= perf_cond_cnt_d;
            perf_taken_cnt_q <= perf_taken_cnt_d;
        end
    end

    assign perf_cond_cnt  = perf_cond_cnt_q;
    assign perf_taken_cnt = perf_taken_cnt_q;
`endif
endmodule
`default_nettype wire

// File: tb/tb_branch_redirect_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_branch_redirect_ctrl
// Brief    : Directed self-checking bench for branch_redirect_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_branch_redirect_ctrl;
    import control_pkg::*;

    logic           clk = 1'b0;
    logic           rstn;
    logic           ex_valid;
    e_br_kind       br_kind;
    e_branch_result cmp_result;
    logic [31:0]    pc;
    logic [31:0]    imm;
    logic [31:0]    rs1_data;
    logic           redirect_valid;
    logic           redirect_ready;
    logic [31:0]    redirect_pc;
    logic           flush;
    logic           stall;
    logic           misalign_exc;
    logic [31:0]    misalign_tval;
`ifdef BRANCH_PERF_CNT_EN
    logic [31:0]    perf_cond_cnt;
    logic [31:0]    perf_taken_cnt;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.DATA_W(32), .FLUSH_CYCLES(2)) dut (
        .clk            (clk),
        .rstn           (rstn),
        .ex_valid       (ex_valid),
        .br_kind        (br_kind),
        .cmp_result     (cmp_result),
        .pc             (pc),
        .imm            (imm),
        .rs1_data       (rs1_data),
        .redirect_valid (redirect_valid),
        .redirect_ready (redirect_ready),
        .redirect_pc    (redirect_pc),
        .flush          (flush),
        .stall          (stall),
        .misalign_exc   (misalign_exc),
        .misalign_tval  (misalign_tval)
`ifdef BRANCH_PERF_CNT_EN
        ,
        .perf_cond_cnt  (perf_cond_cnt),
        .perf_taken_cnt (perf_taken_cnt)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input e_br_kind k, input e_branch_result c,
                         input logic [31:0] p, input logic [31:0] i, input logic [31:0] r);
        ex_valid   = v;
        br_kind    = k;
        cmp_result = c;
        pc         = p;
        imm        = i;
        rs1_data   = r;
    endtask

    task automatic check_ctl(input string tag, input logic rv, input logic fl, input logic st);
        check_eq({tag, ".redirect_valid"}, {31'd0, redirect_valid}, {31'd0, rv});
        check_eq({tag, ".flush"},          {31'd0, flush},          {31'd0, fl});
        check_eq({tag, ".stall"},          {31'd0, stall},          {31'd0, st});
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn           = 1'b0;
        redirect_ready = 1'b0;
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        #23;
        check_ctl("reset", 1'b0, 1'b0, 1'b0);
        check_eq("reset.redirect_pc", redirect_pc, 32'h0);
        check_eq("reset.misalign_exc", {31'd0, misalign_exc}, 32'h0);
        check_eq("reset.misalign_tval", misalign_tval, 32'h0);
        rstn = 1'b1;
        tick();
        check_eq("post_reset.stall", {31'd0, stall}, 32'h0);

        // Taken conditional branch, fetch accepts immediately.
        drive(1'b1, BR_COND, BRES_TAKEN, 32'h100, 32'h40, 32'h0);
        tick();
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        redirect_ready = 1'b1;
        check_ctl("cond.n1", 1'b1, 1'b1, 1'b1);
        check_eq("cond.redirect_pc", redirect_pc, 32'h140);
        tick();
        redirect_ready = 1'b0;
        check_ctl("cond.n2", 1'b0, 1'b1, 1'b1);
        tick();
        check_ctl("cond.n3", 1'b0, 1'b1, 1'b1);
        tick();
        check_ctl("cond.n4", 1'b0, 1'b0, 1'b0);

        // Ten not-taken conditionals, the first with a misaligned-looking target.
        drive(1'b1, BR_COND, BRES_NOT_TAKEN, 32'h102, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (i == 0 || i == 9) begin
                check_ctl($sformatf("nt%0d", i), 1'b0, 1'b0, 1'b0);
                check_eq($sformatf("nt%0d.misalign_exc", i), {31'd0, misalign_exc}, 32'h0);
            end
            pc = pc + 32'h4;
        end
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
        check_eq("perf.cond_after_nt", perf_cond_cnt, 32'd11);
        check_eq("perf.taken_after_nt", perf_taken_cnt, 32'd1);
`endif

        // BR_NONE never faults or redirects even with an odd target.
        drive(1'b1, BR_NONE, BRES_TAKEN, 32'h2, 32'h0, 32'h0);
        tick();
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        check_ctl("none", 1'b0, 1'b0, 1'b0);
        check_eq("none.misalign_exc", {31'd0, misalign_exc}, 32'h0);

        // Misaligned JALR: one-cycle exception, no redirect.
        drive(1'b1, BR_JALR, BRES_NOT_TAKEN, 32'h500, 32'h0, 32'h1003);
        tick();
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        check_eq("jalr.misalign_exc", {31'd0, misalign_exc}, 32'h1);
        check_eq("jalr.misalign_tval", misalign_tval, 32'h1002);
        check_ctl("jalr", 1'b0, 1'b0, 1'b0);
        tick();
        check_eq("jalr.exc_drop", {31'd0, misalign_exc}, 32'h0);

        // Ready while idle is ignored.
        redirect_ready = 1'b1;
        tick();
        check_ctl("idle_ready", 1'b0, 1'b0, 1'b0);
        redirect_ready = 1'b0;

        // JAL with wrap; fetch stalls 5 cycles while new instructions are offered.
        drive(1'b1, BR_JAL, BRES_NOT_TAKEN, 32'hFFFF_FFF0, 32'h20, 32'h0);
        tick();
        drive(1'b1, BR_JAL, BRES_NOT_TAKEN, 32'h5000, 32'h0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            check_ctl($sformatf("jal.wait%0d", i), 1'b1, 1'b1, 1'b1);
            check_eq($sformatf("jal.wait%0d.redirect_pc", i), redirect_pc, 32'h10);
            tick();
        end
        check_eq("jal.wait5.redirect_pc", redirect_pc, 32'h10);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        check_ctl("jal.flush1", 1'b0, 1'b1, 1'b1);
        tick();
        tick();
        check_ctl("jal.idle", 1'b0, 1'b0, 1'b0);
        check_eq("jal.redirect_pc_hold", redirect_pc, 32'h10);
`ifdef BRANCH_PERF_CNT_EN
        check_eq("perf.cond_final", perf_cond_cnt, 32'd11);
        check_eq("perf.taken_final", perf_taken_cnt, 32'd3);
`endif

        // Asynchronous reset during FLUSH.
        drive(1'b1, BR_COND, BRES_TAKEN, 32'h200, 32'h10, 32'h0);
        redirect_ready = 1'b1;
        tick();
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        tick();
        redirect_ready = 1'b0;
        check_ctl("pre_rst.flush", 1'b0, 1'b1, 1'b1);
        #2;
        rstn = 1'b0;
        #1;
        check_ctl("async_rst", 1'b0, 1'b0, 1'b0);
        check_eq("async_rst.redirect_pc", redirect_pc, 32'h0);
`ifdef BRANCH_PERF_CNT_EN
        check_eq("async_rst.perf_taken", perf_taken_cnt, 32'd0);
`endif
        #3;
        rstn = 1'b1;
        drive(1'b1, BR_JAL, BRES_NOT_TAKEN, 32'h300, 32'h8, 32'h0);
        tick();
        drive(1'b0, BR_NONE, BRES_NOT_TAKEN, 32'h0, 32'h0, 32'h0);
        check_ctl("post_rst.jal", 1'b1, 1'b1, 1'b1);
        check_eq("post_rst.redirect_pc", redirect_pc, 32'h308);
        redirect_ready = 1'b1;
        tick();
        redirect_ready = 1'b0;
        tick();
        tick();
        check_ctl("post_rst.idle", 1'b0, 1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
`default_nettype wire
